ft245_tx: RTL and testbench
===========================

# ft245_tx

Transmit path of the FT232H 245-synchronous-FIFO interface: moves bytes from the camera controller (CCD pixel data, ADC/register readback) to the host. It is the write-side counterpart of the existing receive path, which reads host commands via `ft_rxf_n`/`ft_rd_n`/`ft_oe_n`. The block buffers bytes in a small FIFO, drives `ft_wr_n` and the shared data bus while the top-level bus arbiter grants it, and honours FT232H back-pressure on `ft_txe_n`. It also issues send-immediate (`ft_siwu_n`) pulses on request.

## Interface
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 bytes (16).
- `clk`  in  1  ft_clkout, 60 MHz; everything samples on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `din`  in  8  byte to transmit.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  equals !full; reset value 1.
- `flush`  in  1  one-cycle pulse: send-immediate once all bytes queued so far have been written.
- `grant`  in  1  bus ownership from the arbiter; asserted only while the receive path is idle and `ft_oe_n`=1.
- `req`  out  1  bus request: FIFO non-empty, held byte, or flush pending; reset 0.
- `ft_txe_n`  in  1  FT232H transmit FIFO has space (active low).
- `ft_wr_n`  out  1  write strobe, registered; reset 1.
- `ft_siwu_n`  out  1  send immediate, registered; reset 1.
- `ft_data_out`  out  8  byte driven onto `ft_bus`; reset 8'h00.
- `ft_data_oe`  out  1  top drives `ft_bus` = `ft_data_out` when 1; reset 0.
- `level`  out  DEPTH_LOG2+1  FIFO occupancy, 0..2^DEPTH_LOG2; reset 0.

## Operation
- **FIFO push.** Push occurs when `din_valid && din_ready`. When full, `din_ready`=0 even if a pop happens in the same cycle. Pointers are DEPTH_LOG2 bits and wrap modulo depth. `level` increments on push and decrements on pop; a simultaneous push and pop leaves it unchanged.
- **Output register.** Holds exactly one byte (`ft_data_out`) plus a `held` flag.
- **States:** IDLE, WRITE, HOLD, SIWU.
- **IDLE** (`ft_wr_n`=1, `ft_data_oe`=0): if `grant && !ft_txe_n && level!=0`, pop the FIFO head into `ft_data_out`, set `ft_wr_n`=0 and `ft_data_oe`=1, go to WRITE. Otherwise, if flush is pending, `level==0` and `grant`, set `ft_siwu_n`=0 and go to SIWU.
- **WRITE** (`ft_wr_n`=0): at each edge, the byte counts as accepted only if `ft_txe_n`=0 at that edge.
  - Accepted, `grant`=1 and `level!=0`: pop the next byte and stay in WRITE, giving one byte per clock.
  - Accepted, otherwise: `ft_wr_n`=1, `ft_data_oe`=0, go to IDLE.
  - Not accepted (`ft_txe_n`=1): keep the byte (`held`=1), `ft_wr_n`=1, go to HOLD. `ft_data_oe` follows `grant`.
- **HOLD** (`ft_wr_n`=1): the held byte is never discarded. `ft_data_oe` equals the registered `grant`.
  - When `grant && !ft_txe_n`: `ft_wr_n`=0, `ft_data_oe`=1, go to WRITE with the same byte.
- **SIWU**: `ft_siwu_n`=0 for exactly one cycle, then returns to 1. Clear the flush-pending flag and go to IDLE.
- **Flush flag.**
  - A flush pulse sets a pending flag; further pulses while it is pending merge into one.
  - A flush while FIFO and output register are both empty still produces one SIWU pulse.
  - Bytes pushed after the flush but before the SIWU pulse delay the pulse until they are also written.
- **`req`** = (`level!=0`) | `held` | flush_pending | (state!=IDLE).
- **Reset mid-operation.** Asynchronous: all outputs go to their reset values, the FIFO empties, the held byte and pending flush are discarded, and the state returns to IDLE.

## Timing
- Latency: a byte pushed at edge k into an empty, idle block, with `grant`=1 and `ft_txe_n`=0, gives `ft_wr_n`=0 with the byte on `ft_data_out` after edge k+1. It is accepted at edge k+2.
- Sustained throughput is 1 byte/clk while `ft_txe_n`=0, `grant`=1 and the FIFO is non-empty.
- `ft_txe_n` is used combinationally only for the accept/next-state decision. Every FT-facing output is registered.
- `ft_wr_n` and `ft_siwu_n` are never low in the same cycle.
- `ft_wr_n`=0 implies `ft_data_oe`=1.
- The arbiter may drop `grant` only while `ft_wr_n`=1. If it drops while `ft_wr_n`=0, the current byte is still judged at that edge and no further pop occurs.

## Test plan
- **Burst:** push 8'h01..8'h05 back-to-back with `grant`=1 and `ft_txe_n`=0 → `ft_wr_n` goes low 1 cycle after the first push and stays low 5 cycles. Bytes 01..05 are accepted in order, then `level`=0 and `req`=0.
- **Back-pressure:** during the burst, raise `ft_txe_n` for 3 cycles starting while byte 03 is presented → 03 is held and `ft_wr_n` is high for ≥3 cycles. 03 is re-presented after `ft_txe_n` falls; no byte is lost or duplicated.
- **Full:** `ft_txe_n`=1, push 17 bytes → `level`=16 and `din_ready`=0 after 16 pushes; the 17th is refused. Release `ft_txe_n` → 16 bytes drained in order, with pointer wrap verified.
- **Flush:** push 8'hAA, pulse `flush`, push 8'hBB → AA and BB are written, then `ft_siwu_n` is low for exactly 1 cycle. A flush on an empty block → a single SIWU pulse 1 cycle after `grant`.
- **Grant:** `grant`=0 with 4 bytes queued → `req`=1, `ft_wr_n`=1 and `ft_data_oe`=0 until `grant` rises.
- **Reset:** assert `rst` while in HOLD with 5 bytes queued → immediately `ft_wr_n`=1, `ft_data_oe`=0, `ft_data_out`=00, `level`=0, `din_ready`=1 and `req`=0. No write occurs after release.

Source files
------------

// File: rtl/ft245_tx.sv
`default_nettype none
// ============================================================================
// Module   : ft245_tx
// Purpose  : FT232H 245-sync FIFO transmit path: byte FIFO, write strobe,
//            back-pressure hold and send-immediate (SIWU) on flush.
// Revision : 1.0 - initial release
// ============================================================================
module ft245_tx #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            din,
   input  logic                  din_valid,
   output logic                  din_ready,
   input  logic                  flush,
   input  logic                  grant,
   output logic                  req,
   input  logic                  ft_txe_n,
   output logic                  ft_wr_n,
   output logic                  ft_siwu_n,
   output logic [7:0]            ft_data_out,
   output logic                  ft_data_oe,
   output logic [DEPTH_LOG2:0]   level
);

   localparam int c_DEPTH = 1 << DEPTH_LOG2;

   localparam logic [1:0] c_S_IDLE  = 2'd0;
   localparam logic [1:0] c_S_WRITE = 2'd1;
   localparam logic [1:0] c_S_HOLD  = 2'd2;
   localparam logic [1:0] c_S_SIWU  = 2'd3;

   logic [7:0]            r_mem [0:c_DEPTH-1];
   logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_level;
   logic [1:0]            r_state, w_state_nxt;
   logic                  r_wr_n, r_siwu_n, r_data_oe, r_held, r_flush_pend;
   logic [7:0]            r_data_out;

   logic w_push, w_pop, w_full, w_empty;
   logic w_wr_n_nxt, w_siwu_n_nxt, w_oe_nxt, w_held_nxt, w_flush_clr;

   // Occupancy never exceeds depth, so the MSB alone flags full.
   assign w_full    = r_level[DEPTH_LOG2];
   assign w_empty   = (r_level == '0);
   assign w_push    = din_valid && !w_full;

   assign din_ready   = !w_full;
   assign level       = r_level;
   assign ft_wr_n     = r_wr_n;
   assign ft_siwu_n   = r_siwu_n;
   assign ft_data_out = r_data_out;
   assign ft_data_oe  = r_data_oe;
   assign req         = !w_empty || r_held || r_flush_pend || (r_state != c_S_IDLE);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // State and registered FT-facing outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= c_S_IDLE;
         r_wr_n       <= 1'b1;
         r_siwu_n     <= 1'b1;
         r_data_oe    <= 1'b0;
         r_data_out   <= 8'h00;
         r_held       <= 1'b0;
         r_flush_pend <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_wr_n       <= w_wr_n_nxt;
         r_siwu_n     <= w_siwu_n_nxt;
         r_data_oe    <= w_oe_nxt;
         r_held       <= w_held_nxt;
         r_flush_pend <= flush || (r_flush_pend && !w_flush_clr);
         if (w_pop) r_data_out <= r_mem[r_rd_ptr];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_S_IDLE: begin
            if (grant && !ft_txe_n && !w_empty)       w_state_nxt = c_S_WRITE;
            else if (r_flush_pend && w_empty && grant) w_state_nxt = c_S_SIWU;
         end
         c_S_WRITE: begin
            if (ft_txe_n)                  w_state_nxt = c_S_HOLD;
            else if (!(grant && !w_empty)) w_state_nxt = c_S_IDLE;
         end
         c_S_HOLD: begin
            if (grant && !ft_txe_n) w_state_nxt = c_S_WRITE;
         end
         default: w_state_nxt = c_S_IDLE;
      endcase
   end

   always_comb begin
      w_pop        = 1'b0;
      w_wr_n_nxt   = 1'b1;
      w_oe_nxt     = 1'b0;
      w_siwu_n_nxt = 1'b1;
      w_held_nxt   = r_held;
      w_flush_clr  = 1'b0;
      case (r_state)
         c_S_IDLE: begin
            if (grant && !ft_txe_n && !w_empty) begin
               w_pop      = 1'b1;
               w_wr_n_nxt = 1'b0;
               w_oe_nxt   = 1'b1;
            end else if (r_flush_pend && w_empty && grant) begin
               w_siwu_n_nxt = 1'b0;
            end
         end
         c_S_WRITE: begin
            if (!ft_txe_n) begin
               w_held_nxt = 1'b0;
               if (grant && !w_empty) begin
                  w_pop      = 1'b1;
                  w_wr_n_nxt = 1'b0;
                  w_oe_nxt   = 1'b1;
               end
            end else begin
               // Byte refused: keep it and keep driving the bus while granted.
               w_held_nxt = 1'b1;
               w_oe_nxt   = grant;
            end
         end
         c_S_HOLD: begin
            w_oe_nxt = grant;
            if (grant && !ft_txe_n) begin
               w_wr_n_nxt = 1'b0;
               w_oe_nxt   = 1'b1;
            end
         end
         default: w_flush_clr = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_ft245_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ft245_tx
// Purpose  : Self-checking bench for ft245_tx: byte-order scoreboard plus
//            directed burst, back-pressure, full, flush, grant and reset cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ft245_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic       din_valid, din_ready, flush, grant, req;
   logic       ft_txe_n, ft_wr_n, ft_siwu_n, ft_data_oe;
   logic [7:0] ft_data_out;
   logic [4:0] level;

   int total = 0;
   int bad   = 0;
   int wr_low_cnt = 0;
   int siwu_cnt   = 0;
   logic [7:0] q[$];
   logic [7:0] acc_log[$];
   bit m_pend = 0, prev_grant = 0, prev_siwu_low = 0;

   ft245_tx #(.DEPTH_LOG2(4)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .flush(flush), .grant(grant), .req(req), .ft_txe_n(ft_txe_n), .ft_wr_n(ft_wr_n),
      .ft_siwu_n(ft_siwu_n), .ft_data_out(ft_data_out), .ft_data_oe(ft_data_oe), .level(level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wr_low_cnt = 0;
      siwu_cnt   = 0;
      acc_log.delete();
   endtask

   task automatic wait_idle(input int max);
      bit done = 0;
      for (int i = 0; i < max && !done; i++) begin
         if (!req && ft_wr_n && ft_siwu_n) done = 1;
         else tick();
      end
      chk("idle_timeout", {31'd0, done}, 32'd1);
   endtask

   task automatic chk_log(input string name, input logic [7:0] first, input int n);
      chk({name, "_count"}, acc_log.size(), n);
      for (int i = 0; i < n && i < acc_log.size(); i++)
         chk({name, "_byte"}, acc_log[i], first + 8'(i));
   endtask

   // Scoreboard: q holds every pushed byte not yet accepted by the FT232H.
   always @(negedge clk) begin
      logic [7:0] exp_b;
      if (rst) begin
         q.delete();
         m_pend = 0;
         prev_grant = 0;
         prev_siwu_low = 0;
      end else begin
         chk("req", req, (q.size() != 0) || m_pend);
         chk("din_ready", din_ready, level != 5'd16);
         chk("level_range", (int'(level) <= q.size()) && (q.size() - int'(level) <= 1), 1);
         chk("wr_siwu_excl", !ft_wr_n && !ft_siwu_n, 0);
         if (ft_data_oe) chk("oe_needs_grant", prev_grant, 1);
         if (!ft_wr_n) begin
            wr_low_cnt++;
            chk("wr_oe", ft_data_oe, 1);
            chk("wr_inflight", q.size() - int'(level), 1);
         end
         if (!ft_siwu_n) begin
            siwu_cnt++;
            chk("siwu_all_written", q.size(), 0);
            chk("siwu_pending", m_pend, 1);
            chk("siwu_one_cycle", prev_siwu_low, 0);
         end
         if (!ft_wr_n && !ft_txe_n) begin
            if (q.size() == 0) chk("accept_unexpected", 1, 0);
            else begin
               exp_b = q.pop_front();
               chk("accept_byte", ft_data_out, exp_b);
            end
            acc_log.push_back(ft_data_out);
         end
         if (din_valid && din_ready) q.push_back(din);
         prev_siwu_low = !ft_siwu_n;
         if (!ft_siwu_n) m_pend = 0;
         if (flush) m_pend = 1;
         prev_grant = grant;
      end
   end

   task automatic burst(input bit bp);
      clear_log();
      for (int c = 0; c < 14; c++) begin
         din_valid = (c < 5);
         din       = 8'(c + 1);
         ft_txe_n  = bp && (c >= 4) && (c <= 6);
         tick();
         if (c == 0) chk("lat_wr_n_k", ft_wr_n, 1);
         if (c == 1) begin
            chk("lat_wr_n_k1", ft_wr_n, 0);
            chk("lat_data", ft_data_out, 8'h01);
         end
         if (bp && c >= 4 && c <= 6) begin
            chk("bp_wr_n_high", ft_wr_n, 1);
            chk("bp_held_byte", ft_data_out, 8'h03);
         end
         if (bp && c == 7) begin
            chk("bp_represent_wr", ft_wr_n, 0);
            chk("bp_represent_data", ft_data_out, 8'h03);
         end
      end
      din_valid = 0;
      ft_txe_n  = 0;
      chk_log(bp ? "bp" : "burst", 8'h01, 5);
      chk("burst_wr_low_cycles", wr_low_cnt, bp ? 6 : 5);
      chk("burst_level", level, 0);
      chk("burst_req", req, 0);
   endtask

   initial begin
      rst = 1; din = 0; din_valid = 0; flush = 0; grant = 1; ft_txe_n = 0;
      repeat (3) tick();
      chk("rst_wr_n", ft_wr_n, 1);
      chk("rst_siwu_n", ft_siwu_n, 1);
      chk("rst_data", ft_data_out, 8'h00);
      chk("rst_oe", ft_data_oe, 0);
      chk("rst_level", level, 0);
      chk("rst_din_ready", din_ready, 1);
      chk("rst_req", req, 0);
      rst = 0;
      tick();

      burst(0);
      burst(1);

      // Full FIFO with FT232H stalled, then drain across the pointer wrap.
      clear_log();
      ft_txe_n = 1;
      for (int i = 0; i < 17; i++) begin
         din = 8'h20 + 8'(i);
         din_valid = 1;
         tick();
         if (i >= 15) begin
            chk("full_level", level, 16);
            chk("full_din_ready", din_ready, 0);
         end
      end
      din_valid = 0;
      ft_txe_n = 0;
      wait_idle(60);
      chk_log("full", 8'h20, 16);
      chk("full_wr_low_cycles", wr_low_cnt, 16);

      // Flush between two bytes: SIWU only after both are written.
      clear_log();
      din = 8'hAA; din_valid = 1; tick();
      din_valid = 0; flush = 1; tick();
      flush = 0; din = 8'hBB; din_valid = 1; tick();
      din_valid = 0;
      tick(); tick();
      chk("flush_siwu_before", ft_siwu_n, 1);
      tick();
      chk("flush_siwu_low", ft_siwu_n, 0);
      tick();
      chk("flush_siwu_after", ft_siwu_n, 1);
      wait_idle(20);
      chk("flush_siwu_count", siwu_cnt, 1);
      chk("flush_acc_count", acc_log.size(), 2);
      if (acc_log.size() == 2) begin
         chk("flush_acc0", acc_log[0], 8'hAA);
         chk("flush_acc1", acc_log[1], 8'hBB);
      end

      // Flush on an empty block waits for grant.
      clear_log();
      grant = 0; flush = 1; tick();
      flush = 0;
      repeat (3) tick();
      chk("eflush_no_siwu", siwu_cnt, 0);
      chk("eflush_req", req, 1);
      grant = 1; tick();
      chk("eflush_siwu_low", ft_siwu_n, 0);
      tick();
      chk("eflush_siwu_high", ft_siwu_n, 1);
      chk("eflush_siwu_count", siwu_cnt, 1);
      chk("eflush_req_after", req, 0);

      // No grant: bytes wait, bus stays released.
      clear_log();
      grant = 0;
      for (int i = 0; i < 4; i++) begin
         din = 8'h40 + 8'(i); din_valid = 1; tick();
      end
      din_valid = 0;
      repeat (3) tick();
      chk("nogrant_req", req, 1);
      chk("nogrant_wr_n", ft_wr_n, 1);
      chk("nogrant_oe", ft_data_oe, 0);
      chk("nogrant_level", level, 4);
      grant = 1;
      wait_idle(20);
      chk_log("grant", 8'h40, 4);

      // Reset while holding a refused byte with five more queued.
      clear_log();
      ft_txe_n = 1;
      for (int i = 0; i < 6; i++) begin
         din = 8'h50 + 8'(i); din_valid = 1; tick();
      end
      din_valid = 0;
      ft_txe_n = 0; tick();
      ft_txe_n = 1; tick();
      chk("hold_wr_n", ft_wr_n, 1);
      chk("hold_oe", ft_data_oe, 1);
      chk("hold_level", level, 5);
      chk("hold_data", ft_data_out, 8'h50);
      @(negedge clk);
      #2 rst = 1;
      #1;
      chk("arst_wr_n", ft_wr_n, 1);
      chk("arst_oe", ft_data_oe, 0);
      chk("arst_data", ft_data_out, 8'h00);
      chk("arst_level", level, 0);
      chk("arst_din_ready", din_ready, 1);
      chk("arst_req", req, 0);
      tick(); tick();
      rst = 0;
      ft_txe_n = 0;
      clear_log();
      repeat (10) tick();
      chk("post_rst_no_write", wr_low_cnt, 0);
      chk("post_rst_no_accept", acc_log.size(), 0);
      chk("post_rst_req", req, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
